reaction_ctrl: RTL

Control FSM for the reaction-timer datapath. Synchronises and edge-detects the Start/Stop push-buttons, divides the board clock down to the 100 Hz datapath clock, and drives the 2-bit `state` code (idle/delay/timing/display) that the datapath consumes. It also consumes the datapath's `flag` (random delay expired). Sits directly upstream of the datapath; its outputs `Clk100` and `state` connect to the datapath's `Clock` and `state` inputs.

---
 rtl/reaction_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/reaction_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_ctrl
//  Brief    : Control FSM for the reaction-timer datapath. Synchronises and
//             edge-detects the Start/Stop keys, divides the board clock down
//             to the 100 Hz datapath clock and sequences the 2-bit state code
//             idle -> delay -> timing -> display.
//  Options  : REACTION_TIMEOUT_EN - when defined, the timing state is left
//             automatically after TIMEOUT_TICKS ticks with TimedOut set.
//  Revision : 1.0 - initial release
// ============================================================================
module reaction_ctrl #(
    parameter int CLK_HZ        = 50000000,
    parameter int TICK_HZ       = 100,
    parameter int TIMEOUT_TICKS = 99
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       KeyStart,
    input  logic       KeyStop,
    input  logic       flag,
    output logic       Clk100,
    output logic [1:0] state,
    output logic       FalseStart,
    output logic       TimedOut
);

    localparam int                 c_HALF      = CLK_HZ / (2 * TICK_HZ);
    localparam int                 c_DIV_W     = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX   = c_DIV_W'(c_HALF - 1);
    localparam logic [7:0]         c_TMO_TICKS = 8'(TIMEOUT_TICKS);

`ifdef REACTION_TIMEOUT_EN
    localparam bit c_TMO_EN = 1'b1;
`else
    // Timeout gate held off: the tick counter still runs but never forces
    // an exit, so TimedOut can never be set.
    localparam bit c_TMO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_DELAY   = 2'b01,
        S_TIMING  = 2'b10,
        S_DISPLAY = 2'b11
    } state_t;

    logic [1:0]         r_start_sync;
    logic [1:0]         r_stop_sync;
    logic               r_start_prev;
    logic               r_stop_prev;
    logic [1:0]         r_flag_sync;
    logic               r_start_pend;
    logic               r_stop_pend;
    logic [c_DIV_W-1:0] r_div;
    logic               r_clk100;
    logic [7:0]         r_tick;
    state_t             r_state;
    logic               r_false_start;
    logic               r_timed_out;

    logic               w_start_press;
    logic               w_stop_press;
    logic               w_div_wrap;
    logic               w_upd;
    logic               w_timeout;
    state_t             w_state_nxt;
    logic               w_fs_nxt;
    logic               w_to_nxt;

    // Key synchronisers (idle high) plus one extra stage for falling-edge detect; flag synchroniser
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_start_sync <= 2'b11;
            r_stop_sync  <= 2'b11;
            r_start_prev <= 1'b1;
            r_stop_prev  <= 1'b1;
            r_flag_sync  <= 2'b00;
        end else begin
            r_start_sync <= {r_start_sync[0], KeyStart};
            r_stop_sync  <= {r_stop_sync[0], KeyStop};
            r_start_prev <= r_start_sync[1];
            r_stop_prev  <= r_stop_sync[1];
            r_flag_sync  <= {r_flag_sync[0], flag};
        end
    end

    assign w_start_press = r_start_prev & ~r_start_sync[1];
    assign w_stop_press  = r_stop_prev  & ~r_stop_sync[1];

    // Half-period divider producing the datapath clock
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_div    <= '0;
            r_clk100 <= 1'b0;
        end else if (w_div_wrap) begin
            r_div    <= '0;
            r_clk100 <= ~r_clk100;
        end else begin
            r_div    <= r_div + 1'b1;
        end
    end

    assign w_div_wrap = (r_div == c_DIV_MAX);
    // Falling edge of Clk100: state settles half a period before the datapath samples it
    assign w_upd      = w_div_wrap & r_clk100;

    // Sticky press bits; every upd consumes them, but a press landing on the upd cycle carries over
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_start_pend <= 1'b0;
            r_stop_pend  <= 1'b0;
        end else if (w_upd) begin
            r_start_pend <= w_start_press;
            r_stop_pend  <= w_stop_press;
        end else begin
            if (w_start_press) r_start_pend <= 1'b1;
            if (w_stop_press)  r_stop_pend  <= 1'b1;
        end
    end

    // Timing-state tick counter: cleared on entry, saturating increment while timing
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_tick <= 8'd0;
        end else if (w_upd) begin
            if (r_state != S_TIMING && w_state_nxt == S_TIMING) begin
                r_tick <= 8'd0;
            end else if (r_state == S_TIMING && r_tick != 8'hFF) begin
                r_tick <= r_tick + 8'd1;
            end
        end
    end

    assign w_timeout = c_TMO_EN && (r_tick == c_TMO_TICKS);

    // Next-state and status-flag logic; each state looks only at its own key
    always_comb begin
        w_state_nxt = r_state;
        w_fs_nxt    = r_false_start;
        w_to_nxt    = r_timed_out;
        case (r_state)
            S_IDLE: begin
                if (r_start_pend) w_state_nxt = S_DELAY;
            end
            S_DELAY: begin
                if (r_stop_pend) begin
                    w_state_nxt = S_DISPLAY;
                    w_fs_nxt    = 1'b1;
                end else if (r_flag_sync[1]) begin
                    w_state_nxt = S_TIMING;
                end
            end
            S_TIMING: begin
                if (r_stop_pend) begin
                    w_state_nxt = S_DISPLAY;
                end else if (w_timeout) begin
                    w_state_nxt = S_DISPLAY;
                    w_to_nxt    = 1'b1;
                end
            end
            S_DISPLAY: begin
                if (r_start_pend) begin
                    w_state_nxt = S_IDLE;
                    w_fs_nxt    = 1'b0;
                    w_to_nxt    = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and status registers advance only on upd
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state       <= S_IDLE;
            r_false_start <= 1'b0;
            r_timed_out   <= 1'b0;
        end else if (w_upd) begin
            r_state       <= w_state_nxt;
            r_false_start <= w_fs_nxt;
            r_timed_out   <= w_to_nxt;
        end
    end

    assign Clk100     = r_clk100;
    assign state      = r_state;
    assign FalseStart = r_false_start;
    assign TimedOut   = r_timed_out;

endmodule
`default_nettype wire
